// File: rtl/prom_burst.sv
// prom_burst: parametrised piecewise-linear ramp ROM read out as valid/ready bursts.
module prom_burst #(
   parameter int DATA_W    = 8,
   parameter int ADDR_W    = 6,
   parameter int BASE      = 0,
   parameter int SEG_BREAK = 16,
   parameter int STEP_LO   = 1,
   parameter int STEP_HI   = 2
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [ADDR_W-1:0] req_len,
   input  logic              abort,
   output logic              dout_valid,
   input  logic              dout_ready,
   output logic [DATA_W-1:0] dout_data,
   output logic              dout_last,
   output logic              busy
);
   localparam int DEPTH = 1 << ADDR_W;
   typedef enum logic {IDLE, BURST} state_t;
   state_t            r_state, w_next;
   logic [ADDR_W-1:0] r_addr, r_remain;
   logic [DATA_W-1:0] w_mem [DEPTH];
   function automatic logic [DATA_W-1:0] rom_word(input int a);
      int lo, hi;
      lo = (a < SEG_BREAK) ? a : SEG_BREAK - 1;
      hi = (a < SEG_BREAK) ? 0 : a - SEG_BREAK + 1;
      return DATA_W'(BASE + STEP_LO * lo + STEP_HI * hi);
   endfunction
   for (genvar i = 0; i < DEPTH; i++) begin : g_rom
      assign w_mem[i] = rom_word(i);
   end
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) r_state <= IDLE;
      else        r_state <= w_next;
   // abort wins over a simultaneous handshake, so the presented beat is dropped
   always_comb
      w_next = (r_state == IDLE) ? (req_valid ? BURST : IDLE)
             : (abort || (dout_ready && r_remain == '0)) ? IDLE : BURST;
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         r_addr   <= '0;
         r_remain <= '0;
      end else if (r_state == IDLE && req_valid) begin
         r_addr   <= req_addr;
         r_remain <= req_len;
      end else if (r_state == BURST && !abort && dout_ready && r_remain != '0) begin
         r_addr   <= r_addr + ADDR_W'(1);
         r_remain <= r_remain - ADDR_W'(1);
      end
   always_comb begin
      req_ready  = r_state == IDLE;
      busy       = r_state == BURST;
      dout_valid = r_state == BURST;
      dout_data  = dout_valid ? w_mem[r_addr] : '0;
      dout_last  = dout_valid && r_remain == '0;
   end
endmodule

// File: tb/tb_prom_burst.sv
// tb_prom_burst: directed checks of prom_burst at default parameters.
module tb_prom_burst;
   logic       clk, rst_n, req_valid, req_ready, abort, dout_valid, dout_ready, dout_last, busy;
   logic [5:0] req_addr, req_len;
   logic [7:0] dout_data;
   int         checks = 0, failures = 0;
   prom_burst dut (
      .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
      .req_addr(req_addr), .req_len(req_len), .abort(abort), .dout_valid(dout_valid),
      .dout_ready(dout_ready), .dout_data(dout_data), .dout_last(dout_last), .busy(busy)
   );
   initial clk = 0;
   always #5 clk = ~clk;
   function automatic logic [7:0] model(input int i);
      return 8'(i < 16 ? i : 15 + 2 * (i - 15));
   endfunction
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask
   task automatic tick();
      @(posedge clk);
      #1;
   endtask
   task automatic req(input logic [5:0] a, input logic [5:0] l);
      req_valid = 1;
      req_addr  = a;
      req_len   = l;
      tick();
      req_valid = 0;
   endtask
   task automatic beat(input string tag, input logic [7:0] d, input logic l);
      chk({tag, "_valid"}, 32'(dout_valid), 1);
      chk({tag, "_data"}, 32'(dout_data), 32'(d));
      chk({tag, "_last"}, 32'(dout_last), 32'(l));
      chk({tag, "_busy"}, 32'(busy), 1);
      tick();
   endtask
   task automatic idle(input string tag);
      chk({tag, "_valid"}, 32'(dout_valid), 0);
      chk({tag, "_data"}, 32'(dout_data), 0);
      chk({tag, "_busy"}, 32'(busy), 0);
      chk({tag, "_req_ready"}, 32'(req_ready), 1);
   endtask
   initial begin
      int k, c;
      rst_n = 0; req_valid = 0; req_addr = 0; req_len = 0; abort = 0; dout_ready = 1;
      tick(); tick();
      idle("reset");
      chk("reset_last", 32'(dout_last), 0);
      rst_n = 1;
      tick();
      // single beat
      req(0, 0);
      chk("t1_req_ready", 32'(req_ready), 0);
      beat("t1_b0", 8'h00, 1);
      idle("t1_end");
      // across the segment break
      req(14, 3);
      beat("t2_b0", 8'h0E, 0);
      beat("t2_b1", 8'h0F, 0);
      beat("t2_b2", 8'h11, 0);
      beat("t2_b3", 8'h13, 1);
      idle("t2_end");
      // address wrap 63 -> 0
      req(62, 3);
      beat("t3_b0", 8'h6D, 0);
      beat("t3_b1", 8'h6F, 0);
      beat("t3_b2", 8'h00, 0);
      beat("t3_b3", 8'h01, 1);
      idle("t3_end");
      // full table with backpressure pattern 1,0,0
      req(0, 63);
      k = 0; c = 0;
      while (k < 64 && c < 400) begin
         dout_ready = (c % 3 == 0);
         chk($sformatf("t4_valid_%0d", k), 32'(dout_valid), 1);
         chk($sformatf("t4_data_%0d", k), 32'(dout_data), 32'(model(k)));
         chk($sformatf("t4_last_%0d", k), 32'(dout_last), 32'(k == 63));
         tick();
         if (dout_ready) k++;
         c++;
      end
      chk("t4_handshakes", 32'(k), 64);
      dout_ready = 1;
      idle("t4_end");
      // abort on the second beat
      req(0, 9);
      beat("t5_b0", 8'h00, 0);
      abort = 1;
      chk("t5_b1_data", 32'(dout_data), 8'h01);
      tick();
      abort = 0;
      idle("t5_abort");
      req(20, 0);
      beat("t5_new", 8'h19, 1);
      idle("t5_end");
      // abort while idle must not block a request
      abort = 1;
      req(5, 1);
      abort = 0;
      beat("t6_b0", 8'h05, 0);
      beat("t6_b1", 8'h06, 1);
      idle("t6_end");
      // stall holds the beat stable
      req(40, 0);
      dout_ready = 0;
      beat("t7_s0", model(40), 1);
      beat("t7_s1", model(40), 1);
      dout_ready = 1;
      beat("t7_b0", model(40), 1);
      idle("t7_end");
      // asynchronous reset mid-burst
      req(0, 9);
      beat("t8_b0", 8'h00, 0);
      #2 rst_n = 0;
      #1;
      idle("t8_async");
      tick(); tick();
      rst_n = 1;
      tick();
      idle("t8_rel0");
      tick();
      idle("t8_rel1");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/prom_burst.md
Name: prom_burst

Overview:
- Parametrised successor to the team's fixed 64x8 ramp ROM.
- Table contents come from parameters: a two-segment piecewise-linear ramp with configurable width, depth, base, break point and slopes.
- Reads are burst transactions: a request handshake (start address plus length), then one beat per cycle on a valid/ready output stream.
- Supports backpressure, address wrap-around and burst abort. Feeds pattern/test-vector consumers that cannot accept data every cycle.

Parameters:
- DATA_W, 8, data width in bits.
- ADDR_W, 6, address width; depth = 2^ADDR_W.
- BASE, 0, content of mem[0].
- SEG_BREAK, 16, first address of the second segment; legal range 1..2^ADDR_W.
- STEP_LO, 1, increment used for addresses 1..SEG_BREAK-1.
- STEP_HI, 2, increment used for addresses SEG_BREAK..2^ADDR_W-1.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  1  burst request valid.
- req_ready  out  1  block can accept a request.
- req_addr  in  ADDR_W  burst start address.
- req_len  in  ADDR_W  burst length minus 1 (0 means 1 beat, maximum is 2^ADDR_W beats).
- abort  in  1  cancel the current burst.
- dout_valid  out  1  output beat valid.
- dout_ready  in  1  consumer accepts the beat.
- dout_data  out  DATA_W  ROM word.
- dout_last  out  1  final beat of the burst.
- busy  out  1  burst in progress.

Behaviour:
- Contents are fixed at elaboration, all arithmetic mod 2^DATA_W:
  - mem[0] = BASE
  - mem[i] = mem[i-1] + STEP_LO for 1 <= i < SEG_BREAK
  - mem[i] = mem[i-1] + STEP_HI for i >= SEG_BREAK
- Contents are read-only; there is no write path.
- Reset (async assert, sync release):
  - state = IDLE, req_ready = 1.
  - dout_valid = 0, dout_data = 0, dout_last = 0, busy = 0.
  - Internal address and count registers = 0.
- Asserting reset mid-burst drops the burst immediately, with no further beats.
- FSM has two states, IDLE and BURST.
- IDLE:
  - req_ready = 1, busy = 0.
  - On req_valid: latch cur_addr = req_addr and remain = req_len.
  - Next cycle: dout_data = mem[req_addr], dout_valid = 1; enter BURST.
  - Latency from request handshake to first beat is 1 cycle.
- BURST:
  - req_ready = 0, busy = 1.
  - dout_last = dout_valid && (remain == 0).
- Beat transfer happens on the cycle where dout_valid && dout_ready:
  - If remain == 0: next cycle dout_valid = 0, dout_data = 0, state = IDLE.
  - Otherwise: cur_addr += 1, remain -= 1, and the next cycle presents mem[cur_addr+1]. This sustains 1 beat per cycle.
- Backpressure: while dout_valid && !dout_ready, dout_data, dout_last and the internal registers hold stable.
- Address wrap-around: cur_addr increments mod 2^ADDR_W (e.g. 63 -> 0 at default parameters).
- Maximum length: req_len = 2^ADDR_W - 1 gives a full-table read starting at any address; every word is visited exactly once.
- abort in BURST takes priority over a simultaneous handshake:
  - Next cycle: dout_valid = 0, dout_data = 0, state = IDLE.
  - A beat presented in the abort cycle counts as not transferred.
- abort in IDLE is ignored.
- New requests are accepted only in IDLE. There is a minimum of one idle cycle between bursts; req_valid asserted during BURST is held off by req_ready = 0.
- dout_data is 0 whenever dout_valid = 0.

Test Plan:
- Reset, then request addr=0 len=0 with dout_ready=1 -> req_ready=1 after reset; exactly one beat, data 0x00 with last=1 one cycle after the request; busy returns to 0.
- Request addr=14 len=3, ready held high -> beats 0x0E, 0x0F, 0x11, 0x13 on consecutive cycles; last=1 on 0x13 only (segment break at 16).
- Request addr=62 len=3 -> beats 0x6D, 0x6F, 0x00, 0x01 (wrap 63 -> 0; mem[63]=0x6F).
- Request addr=0 len=63 with dout_ready toggling 1,0,0,1,... -> all 64 words in order, data stable during stalls, exactly 64 handshakes, last on mem[63]=0x6F.
- Abort on the 2nd beat of addr=0 len=9 -> dout_valid=0 the next cycle; req_ready=1; a new request addr=20 len=0 returns 0x19.
- Assert rst_n=0 mid-burst -> outputs go to 0 asynchronously; after release, req_ready=1 and no residual beats.
